// File: rtl/prince_sbox_stage.sv
// PRINCE S-layer stage: key/constant add, then 16 parallel 4-bit S-boxes, two elastic registers.
// Optional inverse S-box path is enabled by defining PRINCE_SBOX_INV_EN.
module prince_sbox_stage #(
  parameter int unsigned DATA_W  = 64,
  parameter bit          KEY_ADD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] rk_in,
  input  logic [DATA_W-1:0] rc_in,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned NumNibbles = 16;

  if (DATA_W != 64) begin : g_bad_width
    $error("prince_sbox_stage: DATA_W must be 64");
  end

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    unique case (x)
      4'h0: y = 4'hB;
      4'h1: y = 4'hF;
      4'h2: y = 4'h3;
      4'h3: y = 4'h2;
      4'h4: y = 4'hA;
      4'h5: y = 4'hC;
      4'h6: y = 4'h9;
      4'h7: y = 4'h1;
      4'h8: y = 4'h6;
      4'h9: y = 4'h7;
      4'hA: y = 4'h8;
      4'hB: y = 4'h0;
      4'hC: y = 4'hE;
      4'hD: y = 4'h5;
      4'hE: y = 4'hD;
      4'hF: y = 4'h4;
    endcase
    return y;
  endfunction

`ifdef PRINCE_SBOX_INV_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    unique case (x)
      4'h0: y = 4'hB;
      4'h1: y = 4'h7;
      4'h2: y = 4'h3;
      4'h3: y = 4'h2;
      4'h4: y = 4'hF;
      4'h5: y = 4'hD;
      4'h6: y = 4'h8;
      4'h7: y = 4'h9;
      4'h8: y = 4'hA;
      4'h9: y = 4'h6;
      4'hA: y = 4'h4;
      4'hB: y = 4'h0;
      4'hC: y = 4'h5;
      4'hD: y = 4'hE;
      4'hE: y = 4'hC;
      4'hF: y = 4'h1;
    endcase
    return y;
  endfunction
`endif

  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_valid;
  logic              r_rdy_en;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_accept;
  logic [DATA_W-1:0] w_s1_next;
  logic [DATA_W-1:0] w_s2_next;

  // in_ready depends combinationally on out_ready through the advance chain.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && r_rdy_en;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_s1_next = in_data;
    if (KEY_ADD) begin
      w_s1_next = in_data ^ rk_in ^ rc_in;
    end
  end

`ifdef PRINCE_SBOX_INV_EN
  logic r_s1_inv;

  always_comb begin
    w_s2_next = '0;
    for (int i = 0; i < NumNibbles; i++) begin
      w_s2_next[4*i +: 4] = r_s1_inv ? sbox_inv(r_s1_data[4*i +: 4])
                                     : sbox_fwd(r_s1_data[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_inv <= 1'b0;
    end else if (w_accept) begin
      r_s1_inv <= in_inv;
    end
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;

  always_comb begin
    w_s2_next = '0;
    for (int i = 0; i < NumNibbles; i++) begin
      w_s2_next[4*i +: 4] = sbox_fwd(r_s1_data[4*i +: 4]);
    end
  end
`endif

  // Holds in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_next;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule
